// File: rtl/bus_xfer_pkg.sv
// bus_xfer_pkg: shared state encoding, select-width helper and strobe-inactive level for the bus transfer sequencer
package bus_xfer_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, LATCH, HOLD} state_t;
  localparam logic STROBE_OFF = 1'b1;
  function automatic int sel_w(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/onehot_n_dec.sv
// onehot_n_dec: select-to-one-hot decoder with enable, active-low outputs (all high when disabled)
module onehot_n_dec #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         en,
  input  logic [W-1:0] sel,
  output logic [N-1:0] y_n
);
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign y_n[i] = !(en && sel == W'(i));
  end
endmodule

// File: rtl/bus_xfer_seq.sv
// bus_xfer_seq: one register-to-register transfer per request over a shared bus (drive, settle, load, hold); BUS_XFER_IMM_EN adds an immediate-driver source
module bus_xfer_seq import bus_xfer_pkg::*; #(
  parameter int NREG = 4,
  parameter int SETTLE = 1,
  localparam int SW = sel_w(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [SW-1:0]   req_src,
  input  logic [SW-1:0]   req_dst,
`ifdef BUS_XFER_IMM_EN
  input  logic            req_imm,
  output logic            imm_oe_n,
`endif
  output logic [NREG-1:0] re_n,
  output logic [NREG-1:0] we_n,
  output logic            busy,
  output logic            done,
  output logic            err
);
  localparam int CW = sel_w(SETTLE);
  localparam logic [SW:0] NMAX = (SW+1)'(NREG);
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [SW-1:0] src_q, dst_q, src_nxt, dst_nxt;
  logic imm_in, imm_q, imm_nxt, take, bad, acc;
  logic [NREG-1:0] re_nxt, we_nxt;
  logic [NREG:0] drv_n;
`ifdef BUS_XFER_IMM_EN
  assign imm_in = req_imm;
  assign drv_n = {imm_oe_n, we_n};
`else
  assign imm_in = 1'b0;
  assign drv_n = {STROBE_OFF, we_n};
`endif
  assign take = state == IDLE && req_valid;
  assign bad = (!imm_in && (req_src == req_dst || {1'b0, req_src} >= NMAX)) || {1'b0, req_dst} >= NMAX;
  assign acc = take && !bad;
  assign src_nxt = acc ? req_src : src_q;
  assign dst_nxt = acc ? req_dst : dst_q;
  assign imm_nxt = acc ? imm_in : imm_q;
  assign cnt_nxt = acc ? CW'(SETTLE - 1) : (state == DRIVE && cnt != '0) ? cnt - CW'(1) : cnt;
  assign nxt = state == IDLE ? (acc ? DRIVE : IDLE) :
               state == DRIVE ? (cnt == '0 ? LATCH : DRIVE) :
               state == LATCH ? HOLD : IDLE;
  onehot_n_dec #(.N(NREG), .W(SW)) u_we (.en(nxt != IDLE && !imm_nxt), .sel(src_nxt), .y_n(we_nxt));
  onehot_n_dec #(.N(NREG), .W(SW)) u_re (.en(nxt == LATCH), .sel(dst_nxt), .y_n(re_nxt));
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      imm_q     <= 1'b0;
      re_n      <= {NREG{STROBE_OFF}};
      we_n      <= {NREG{STROBE_OFF}};
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      state     <= nxt;
      cnt       <= cnt_nxt;
      src_q     <= src_nxt;
      dst_q     <= dst_nxt;
      imm_q     <= imm_nxt;
      re_n      <= re_nxt;
      we_n      <= we_nxt;
      busy      <= nxt != IDLE;
      done      <= state == HOLD;
      err       <= take && bad;
      req_ready <= nxt == IDLE;
    end
`ifdef BUS_XFER_IMM_EN
    imm_oe_n <= rst ? STROBE_OFF : !(nxt != IDLE && imm_nxt);
`endif
  end
  assert property (@(posedge clk) disable iff (rst) $onehot0(~drv_n));
  assert property (@(posedge clk) disable iff (rst) $onehot0(~re_n));
  assert property (@(posedge clk) disable iff (rst) !(|(~re_n)) || ((|(~drv_n)) && (~re_n & ~we_n) == '0));
endmodule

// File: tb/tb_bus_xfer_seq.sv
// tb_bus_xfer_seq: timeline-model and directed checks of bus_xfer_seq at SETTLE=1 and SETTLE=3
module tb_bus_xfer_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst1 = 1'b1, v1 = 1'b0, rst3 = 1'b1, v3 = 1'b0;
  logic [1:0] s1 = '0, d1 = '0, s3 = '0, d3 = '0;
  logic rdy1, busy1, done1, err1, rdy3, busy3, done3, err3;
  logic [3:0] re1, we1, re3, we3;
  logic [3:0] cells = 4'b0010;
  int tests = 0, fails = 0;
  int k[2] = '{0, 0};
  int st[2] = '{1, 3};
  logic [1:0] ms[2], md[2];
  logic e_done[2], e_err[2];
  bit started = 1'b0;
  bus_xfer_seq #(.NREG(4), .SETTLE(1)) u1 (
    .clk(clk), .rst(rst1), .req_valid(v1), .req_ready(rdy1), .req_src(s1), .req_dst(d1),
    .re_n(re1), .we_n(we1), .busy(busy1), .done(done1), .err(err1)
  );
  bus_xfer_seq #(.NREG(4), .SETTLE(3)) u3 (
    .clk(clk), .rst(rst3), .req_valid(v3), .req_ready(rdy3), .req_src(s3), .req_dst(d3),
    .re_n(re3), .we_n(we3), .busy(busy3), .done(done3), .err(err3)
  );
  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chkn(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input int i, input logic r, input logic v, input logic [1:0] s, input logic [1:0] d);
    e_done[i] = 1'b0;
    e_err[i] = 1'b0;
    if (r) k[i] = 0;
    else if (k[i] == 0) begin
      if (v && s != d) begin
        k[i] = 1;
        ms[i] = s;
        md[i] = d;
      end else e_err[i] = v;
    end else begin
      e_done[i] = k[i] == st[i] + 2;
      k[i] = e_done[i] ? 0 : k[i] + 1;
    end
  endtask
  function automatic logic [3:0] exp_we(input int i);
    return k[i] != 0 ? ~(4'b0001 << ms[i]) : 4'b1111;
  endfunction
  function automatic logic [3:0] exp_re(input int i);
    return k[i] == st[i] + 1 ? ~(4'b0001 << md[i]) : 4'b1111;
  endfunction
  always @(posedge clk) begin
    step(0, rst1, v1, s1, d1);
    step(1, rst3, v3, s3, d3);
    started = 1'b1;
  end
  always @(negedge clk) if (started) begin
    chk4("u1_we", we1, exp_we(0));
    chk4("u1_re", re1, exp_re(0));
    chk1("u1_busy", busy1, k[0] != 0);
    chk1("u1_ready", rdy1, k[0] == 0);
    chk1("u1_done", done1, e_done[0]);
    chk1("u1_err", err1, e_err[0]);
    chk4("u3_we", we3, exp_we(1));
    chk4("u3_re", re3, exp_re(1));
    chk1("u3_busy", busy3, k[1] != 0);
    chk1("u3_ready", rdy3, k[1] == 0);
    chk1("u3_done", done3, e_done[1]);
    chk1("u3_err", err3, e_err[1]);
  end
  always @(negedge clk) if (started)
    for (int i = 0; i < 4; i++) if (!re1[i]) cells[i] = |(cells & ~we1);
  task automatic wait_done(output int n);
    n = 1;
    while (!done1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask
  initial begin
    int n;
    repeat (3) begin
      @(negedge clk);
      chk4("rst_re", re1, 4'b1111);
      chk4("rst_we", we1, 4'b1111);
      chk1("rst_ready", rdy1, 1'b1);
      chk1("rst_busy", busy1, 1'b0);
    end
    rst1 = 1'b0;
    v1 = 1'b1; s1 = 2'd1; d1 = 2'd2;
    @(negedge clk);
    v1 = 1'b0;
    chk4("x12_we_c1", we1, 4'b1101);
    chk4("x12_re_c1", re1, 4'b1111);
    @(negedge clk);
    chk4("x12_we_c2", we1, 4'b1101);
    chk4("x12_re_c2", re1, 4'b1011);
    @(negedge clk);
    chk4("x12_we_c3", we1, 4'b1101);
    chk4("x12_re_c3", re1, 4'b1111);
    @(negedge clk);
    chk1("x12_done_c4", done1, 1'b1);
    chk1("x12_ready_c4", rdy1, 1'b1);
    chk4("x12_we_c4", we1, 4'b1111);
    chk4("x12_cells", cells, 4'b0110);
    v1 = 1'b1; s1 = 2'd3; d1 = 2'd3;
    @(negedge clk);
    v1 = 1'b0;
    chk1("inv_err", err1, 1'b1);
    chk4("inv_we", we1, 4'b1111);
    chk4("inv_re", re1, 4'b1111);
    chk1("inv_done", done1, 1'b0);
    chk1("inv_busy", busy1, 1'b0);
    @(negedge clk);
    chk1("inv_err_once", err1, 1'b0);
    v1 = 1'b1; s1 = 2'd0; d1 = 2'd1;
    @(negedge clk);
    s1 = 2'd1; d1 = 2'd3;
    chk4("b2b_first_we", we1, 4'b1110);
    wait_done(n);
    chkn("b2b_first_lat", n, 4);
    chk1("b2b_ready_in_done", rdy1, 1'b1);
    @(negedge clk);
    v1 = 1'b0;
    chk4("b2b_second_we", we1, 4'b1101);
    wait_done(n);
    chkn("b2b_second_gap", n, 4);
    chk4("b2b_cells", cells, 4'b0100);
    v1 = 1'b1; s1 = 2'd0; d1 = 2'd2;
    @(negedge clk);
    v1 = 1'b0;
    @(negedge clk);
    chk4("mid_latch_re", re1, 4'b1011);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    chk4("mid_rst_re", re1, 4'b1111);
    chk4("mid_rst_we", we1, 4'b1111);
    chk1("mid_rst_done", done1, 1'b0);
    chk1("mid_rst_busy", busy1, 1'b0);
    @(negedge clk);
    chk1("mid_rst_no_done", done1, 1'b0);
    chk1("mid_rst_no_err", err1, 1'b0);
    v1 = 1'b1; s1 = 2'd2; d1 = 2'd0;
    @(negedge clk);
    v1 = 1'b0;
    wait_done(n);
    chkn("post_rst_lat", n, 4);
    rst3 = 1'b0;
    v3 = 1'b1; s3 = 2'd0; d3 = 2'd3;
    @(negedge clk);
    v3 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk4("s3_we", we3, c <= 5 ? 4'b1110 : 4'b1111);
      chk4("s3_re", re3, c == 4 ? 4'b0111 : 4'b1111);
      chk1("s3_done", done3, c == 6);
      if (c < 6) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/bus_xfer_seq.md
Name: bus_xfer_seq

Overview:
- Control sequencer sitting directly upstream of the team's single-bit storage cells (`dff`) and the registers built from them.
- Drives each cell's active-low strobes: `re` (load from d) and `we` (drive q onto the shared bus).
- Performs one register-to-register transfer per request over the shared bus: output-enable source, settle, load destination, hold, release.
- Guarantees that at most one source drives the bus and that no load strobe is active outside the transfer window.

Parameters:
- NREG, 4: number of registers on the shared bus (≥2).
- SETTLE, 1: cycles the source drives the bus before the load strobe (≥1).
- SW, $clog2(NREG) (min 1): width of the register-select fields (derived localparam).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  transfer request.
- req_ready  out  1  high in IDLE only; the request is accepted when req_valid && req_ready at the edge.
- req_src  in  SW  source register index.
- req_dst  in  SW  destination register index.
- re_n  out  NREG  per-register load strobe, active low, to the cell's `re`.
- we_n  out  NREG  per-register output enable, active low, to the cell's `we`.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle pulse on transfer completion.
- err  out  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset, sampled at the clock edge:
  - all outputs are registered;
  - re_n = all ones, we_n = all ones, busy = 0, done = 0, err = 0, req_ready = 1;
  - state = IDLE, settle counter = 0.
- States are IDLE, DRIVE, LATCH and HOLD.
  - IDLE: all strobes high. On accept with a valid request, latch src/dst and go to DRIVE.
  - DRIVE: we_n[src] = 0 and all re_n high. Lasts exactly SETTLE cycles, counted by a down-counter loaded with SETTLE-1. Then go to LATCH.
  - LATCH: we_n[src] = 0 and re_n[dst] = 0 for exactly 1 cycle. Then go to HOLD.
  - HOLD: we_n[src] = 0 and re_n all high for 1 cycle, which is the data hold after load. Then go to IDLE with done = 1 for that first IDLE cycle.
- Latency: accept edge to done high is SETTLE+3 cycles.
  - req_ready is high again in the done cycle, so back-to-back transfers are allowed with zero idle gap.
- Invalid request is defined as src == dst, src ≥ NREG, or dst ≥ NREG.
  - It is accepted in IDLE and consumed.
  - err = 1 for one cycle.
  - The state stays IDLE, no strobe toggles, and done stays 0.
- req_valid while busy: req_ready = 0, nothing is latched, and inputs are ignored.
  - Requesters must hold their request until accepted.
- Strobe invariants, to be checked by assertion:
  - at most one we_n bit low;
  - at most one re_n bit low;
  - re_n[i] low implies some we_n[j] low with j ≠ i.
- Reset mid-transfer: on the next edge all strobes go high and the state returns to IDLE. No done and no err are issued.
- Selection fields are latched at accept, so changes to req_src/req_dst during busy have no effect.

Optional Feature:
- Macro: BUS_XFER_IMM_EN.
- When defined:
  - adds input `req_imm` (1) and output `imm_oe_n` (1, active low, reset 1);
  - a request with req_imm = 1 uses the external immediate driver as the source: imm_oe_n = 0 replaces we_n[src] in DRIVE, LATCH and HOLD;
  - req_src is ignored and the src == dst check is skipped;
  - the strobe invariants treat imm_oe_n as an extra source.
- When undefined: neither port exists and every transfer is register-to-register.

Decomposition:
- Shared package `bus_xfer_pkg`:
  - state enum (IDLE, DRIVE, LATCH, HOLD);
  - the function computing SW from NREG;
  - strobe-inactive constant (1'b1).
- Natural sub-module: `onehot_n_dec`, an SW-to-NREG active-low one-hot decoder with an enable. Instantiated twice, once for re_n and once for we_n.

Test Plan:
- rst = 1 for 3 cycles, then 0 → re_n = 4'b1111, we_n = 4'b1111, req_ready = 1, busy = 0 throughout reset.
- NREG = 4, SETTLE = 1; request src = 1, dst = 2 → we_n = 4'b1101 for 3 cycles, re_n = 4'b1011 only in the middle cycle, done at accept+4.
  - Bench models 4 `dff` cells on the bus with reg1 = 1 and reg2 = 0; after the transfer, reg2 reads 1.
- Request src = 3, dst = 3 → err pulse of 1 cycle, strobes never leave 4'b1111, done = 0.
- Two back-to-back requests (0→1 then 1→3) with req_valid held high → second is accepted in the done cycle; second transfer's done lands 4 cycles after the first.
- rst asserted during LATCH → next edge: re_n = we_n = 4'b1111, IDLE, no done. A new request after reset completes normally.
- SETTLE = 3 build → we_n[src] low for 5 cycles, re_n[dst] low only in cycle 4, done at accept+6.
